// File: rtl/button_conditioner.sv
// button_conditioner: synchronises, debounces and edge-detects the raw UP/DOWN
// push buttons. It emits one-cycle press pulses and clean debounced levels, and
// suppresses the press pulse of a channel while the other channel is held.
// Optional feature macro: AUTO_REPEAT_EN adds a per-channel hold-to-repeat FSM.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic UP,
  input  logic DOWN,
  output logic up_pulse,
  output logic down_pulse,
  output logic up_level,
  output logic down_level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject parameter values below the minimum the counters can handle.
  generate
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
      $error("button_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
    end
  endgenerate

  // Channel index 0 = up, 1 = down throughout.
  logic [1:0]       raw;
  logic [1:0]       sync_p0;
  logic [1:0]       sync_p1;
  logic [1:0]       level;
  logic [CNT_W-1:0] cnt [2];
  logic [1:0]       settle;
  logic [1:0]       rise;
  logic [1:0]       press;
  logic [1:0]       pulse_d;

  assign raw = {DOWN, UP};

  // Two-flop synchroniser and per-channel debounce counter / level register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      level   <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          level[i] <= sync_p1[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A channel's level flips on this edge when its count is about to expire.
  assign settle[0] = (sync_p1[0] != level[0]) && (cnt[0] == CNT_LAST);
  assign settle[1] = (sync_p1[1] != level[1]) && (cnt[1] == CNT_LAST);
  assign rise      = settle & ~level;

  // A press only counts when the other button is neither held nor rising now.
  assign press[0] = rise[0] & ~level[1] & ~rise[1];
  assign press[1] = rise[1] & ~level[0] & ~rise[0];

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_t;

  rpt_state_t       state     [2];
  rpt_state_t       state_nxt [2];
  logic [RPT_W-1:0] rcnt      [2];
  logic [RPT_W-1:0] rcnt_nxt  [2];
  logic [1:0]       rpt_fire;
  logic [1:0]       fall;
  logic [1:0]       other;

  assign fall  = settle & level;
  assign other = {level[0], level[1]};

  // Repeat FSM next state: counter holds while the other button is held.
  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < 2; i++) begin
      state_nxt[i] = state[i];
      rcnt_nxt[i]  = rcnt[i];
      case (state[i])
        RPT_IDLE: begin
          if (press[i]) begin
            state_nxt[i] = RPT_DELAY;
            rcnt_nxt[i]  = '0;
          end
        end
        RPT_DELAY: begin
          if (!other[i]) begin
            if (rcnt[i] == DELAY_LAST) begin
              rpt_fire[i]  = 1'b1;
              rcnt_nxt[i]  = '0;
              state_nxt[i] = RPT_REPEAT;
            end else begin
              rcnt_nxt[i] = rcnt[i] + RPT_W'(1);
            end
          end
        end
        RPT_REPEAT: begin
          if (!other[i]) begin
            if (rcnt[i] == PERIOD_LAST) begin
              rpt_fire[i] = 1'b1;
              rcnt_nxt[i] = '0;
            end else begin
              rcnt_nxt[i] = rcnt[i] + RPT_W'(1);
            end
          end
        end
        default: begin
          state_nxt[i] = RPT_IDLE;
          rcnt_nxt[i]  = '0;
        end
      endcase
      // Release always wins: back to idle, no pulse on the release edge.
      if (fall[i]) begin
        state_nxt[i] = RPT_IDLE;
        rcnt_nxt[i]  = '0;
        rpt_fire[i]  = 1'b0;
      end
    end
  end

  // Repeat FSM state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        state[i] <= RPT_IDLE;
        rcnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        state[i] <= state_nxt[i];
        rcnt[i]  <= rcnt_nxt[i];
      end
    end
  end

  assign pulse_d = press | rpt_fire;
`else
  assign pulse_d = press;
`endif

  // Registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_pulse   <= 1'b0;
      down_pulse <= 1'b0;
    end else begin
      up_pulse   <= pulse_d[0];
      down_pulse <= pulse_d[1];
    end
  end

  assign up_level   = level[0];
  assign down_level = level[1];

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and randomized stimulus for button_conditioner,
// checked every cycle against a sample-history model of the button rules.
module tb_button_conditioner;

  localparam int DB   = 4;
  localparam int RD   = 10;
  localparam int RP   = 5;
  localparam int MAXE = 4096;
`ifdef AUTO_REPEAT_EN
  localparam int EXP_HOLD = 7;
`else
  localparam int EXP_HOLD = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic UP;
  logic DOWN;
  logic up_pulse;
  logic down_pulse;
  logic up_level;
  logic down_level;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .UP        (UP),
    .DOWN      (DOWN),
    .up_pulse  (up_pulse),
    .down_pulse(down_pulse),
    .up_level  (up_level),
    .down_level(down_level)
  );

  always #10 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Model state: raw samples since reset, indexed by edge number (1 = first edge).
  bit rawh [2][MAXE];
  int n;
  bit lvl [2];
  int last_flip [2];
  bit exp_pulse [2];
  bit active [2];
  int elapsed [2];

  // Observation counters for directed sections.
  int n_up_p, n_dn_p, n_dn_lvl, first_up_n;

  task automatic chk(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int c = 0; c < 2; c++) begin
      lvl[c] = 1'b0;
      last_flip[c] = 0;
      exp_pulse[c] = 1'b0;
      active[c] = 1'b0;
      elapsed[c] = 0;
    end
  endtask

  // Synchronised value seen just after edge m: the raw sample taken one edge earlier.
  function automatic bit s_at(input int c, input int m);
    return (m >= 2) ? rawh[c][m-1] : 1'b0;
  endfunction

  task automatic model_edge(input bit u, input bit d);
    bit flip [2];
    bit rise [2];
    bit fall [2];
    bit press [2];
    bit rp [2];
    n++;
    rawh[0][n] = u;
    rawh[1][n] = d;
    // Level flips once the last DB pre-edge synchronised samples all disagree with it.
    for (int c = 0; c < 2; c++) begin
      flip[c] = 1'b0;
      if (n - last_flip[c] >= DB) begin
        flip[c] = 1'b1;
        for (int j = 1; j <= DB; j++)
          if (s_at(c, n - j) == lvl[c]) flip[c] = 1'b0;
      end
      rise[c] = flip[c] & ~lvl[c];
      fall[c] = flip[c] & lvl[c];
    end
    press[0] = rise[0] & ~lvl[1] & ~rise[1];
    press[1] = rise[1] & ~lvl[0] & ~rise[0];
    for (int c = 0; c < 2; c++) begin
      rp[c] = 1'b0;
`ifdef AUTO_REPEAT_EN
      // Repeats: count edges since the press on which the other button was up.
      if (active[c]) begin
        if (fall[c]) begin
          active[c] = 1'b0;
        end else if (!lvl[1-c]) begin
          elapsed[c]++;
          if (elapsed[c] == RD || (elapsed[c] > RD && (elapsed[c] - RD) % RP == 0))
            rp[c] = 1'b1;
        end
      end
      if (press[c]) begin
        active[c] = 1'b1;
        elapsed[c] = 0;
      end
`endif
      exp_pulse[c] = press[c] | rp[c];
    end
    for (int c = 0; c < 2; c++) begin
      if (flip[c]) begin
        lvl[c] = ~lvl[c];
        last_flip[c] = n;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_up_pulse"}, up_pulse, 1'b0);
    chk({tag, "_down_pulse"}, down_pulse, 1'b0);
    chk({tag, "_up_level"}, up_level, 1'b0);
    chk({tag, "_down_level"}, down_level, 1'b0);
  endtask

  task automatic clear_counts();
    n_up_p = 0;
    n_dn_p = 0;
    n_dn_lvl = 0;
    first_up_n = -1;
  endtask

  // Drive inputs, let one rising edge pass, then check all outputs against the model.
  task automatic tick(input bit u, input bit d);
    UP = u;
    DOWN = d;
    @(posedge clk);
    model_edge(u, d);
    #1;
    chk("up_level", up_level, lvl[0]);
    chk("down_level", down_level, lvl[1]);
    chk("up_pulse", up_pulse, exp_pulse[0]);
    chk("down_pulse", down_pulse, exp_pulse[1]);
    chk("pulse_exclusive", up_pulse & down_pulse, 1'b0);
    if (up_pulse === 1'b1) begin
      n_up_p++;
      if (first_up_n < 0) first_up_n = n;
    end
    if (down_pulse === 1'b1) n_dn_p++;
    if (down_level === 1'b1) n_dn_lvl++;
  endtask

  initial begin
    int base;
    bit u, d, gl;
    int len;

    rst_n = 1'b0;
    UP = 1'b0;
    DOWN = 1'b0;
    model_reset();
    #3;
    check_zero("reset");
    #2;
    rst_n = 1'b1;

    // Clean press held for 40 samples, then released.
    clear_counts();
    base = n;
    repeat (40) tick(1'b1, 1'b0);
    repeat (12) tick(1'b0, 1'b0);
    chkn("press_latency", first_up_n - base, 6);
    chkn("hold_up_pulses", n_up_p, EXP_HOLD);
    chkn("hold_down_pulses", n_dn_p, 0);

    // Glitchy down button never settles.
    clear_counts();
    repeat (3) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    repeat (3) tick(1'b0, 1'b1);
    repeat (8) tick(1'b0, 1'b0);
    chkn("glitch_down_level_cycles", n_dn_lvl, 0);
    chkn("glitch_down_pulses", n_dn_p, 0);

    // Both pressed together, then down re-pressed while up is held.
    clear_counts();
    repeat (20) tick(1'b1, 1'b1);
    repeat (8) tick(1'b1, 1'b0);
    repeat (12) tick(1'b1, 1'b1);
    repeat (10) tick(1'b0, 1'b0);
    chkn("both_pulses", n_up_p + n_dn_p, 0);
    chkn("both_down_level_seen", int'(n_dn_lvl > 0), 1);

    // Reset in the middle of a pending count with up held throughout.
    clear_counts();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    model_reset();
    rst_n = 1'b1;
    clear_counts();
    repeat (12) tick(1'b1, 1'b0);
    chkn("reset_repress_edge", first_up_n, 6);
    chkn("reset_repress_pulses", n_up_p, 1);
    repeat (10) tick(1'b0, 1'b0);

    // Randomized hold segments with occasional single-sample glitches.
    for (int seg = 0; seg < 60; seg++) begin
      len = $urandom_range(1, 30);
      u = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 3) == 0);
      for (int t = 0; t < len; t++) begin
        gl = 1'($urandom_range(0, 9) == 0);
        tick(u ^ gl, d);
      end
    end
    repeat (10) tick(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions the raw UP/DOWN push-button inputs before they reach the LED control logic: 2-FF synchroniser, per-channel debouncer, press-edge detector.
- Emits single-cycle press pulses plus clean debounced levels.
- Resolves simultaneous presses of both buttons.
- Sits directly upstream of the LED counter/control top; that stage consumes only the pulse outputs as step commands.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive cycles a synchronised input must differ from the debounced level before the level flips; legal range 2 and up.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): debounce counter width (derived, not overridden).
- REPEAT_DELAY, 50000000: cycles from the initial press pulse to the first auto-repeat pulse; used only with AUTO_REPEAT_EN; 2 and up.
- REPEAT_PERIOD, 10000000: cycles between subsequent auto-repeat pulses; used only with AUTO_REPEAT_EN; 2 and up.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- UP  in  1  raw, asynchronous, bouncing up button; high = pressed.
- DOWN  in  1  raw, asynchronous, bouncing down button; high = pressed.
- up_pulse  out  1  one-cycle press/repeat pulse, up channel (registered).
- down_pulse  out  1  one-cycle press/repeat pulse, down channel (registered).
- up_level  out  1  debounced up level (registered).
- down_level  out  1  debounced down level (registered).

Behaviour:
- Interface (decided): one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n=0, every flop clears immediately: sync stages, levels, counters, FSMs. All four outputs reset to 0.
- Synchroniser:
  - Two flops per input.
  - sync2 reflects a raw change after 2 rising edges.
- Debounce counter, per channel (cnt, CNT_W bits):
  - On an edge where sync2 == level: cnt <= 0.
  - Else, if cnt == DEBOUNCE_CYCLES-1: level <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any bounce back to the level value restarts the count.
- Latency: level flips on the (2+DEBOUNCE_CYCLES)th rising edge, counting the first edge that samples the raw input at its new value.
- Press detect:
  - The press pulse asserts on the same edge where the level goes 0->1.
  - It lasts exactly one cycle.
  - Release (1->0) produces no pulse.
- Conflict rule:
  - A channel's press pulse is suppressed if the other channel's level is 1 before that edge.
  - If both levels rise on the same edge, both pulses are suppressed.
  - up_pulse and down_pulse are never high in the same cycle.
  - Levels are never suppressed.
- Reset mid-operation:
  - A button held through rst_n deassertion is treated as a new press, since the level restarts at 0.
  - It pulses 2+DEBOUNCE_CYCLES edges after release of reset.
- Reset asserted during a pending count discards the count.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined: each channel has a 3-state FSM (IDLE, DELAY, REPEAT) with its own repeat counter.
  - IDLE->DELAY: on an emitted (non-suppressed) press pulse; counter cleared.
  - DELAY->REPEAT: when the counter reaches REPEAT_DELAY-1 while the level is still 1. Emit a pulse; counter cleared.
  - In REPEAT: emit a pulse each time the counter reaches REPEAT_PERIOD-1; counter clears.
  - Any state -> IDLE on the edge where the level goes 0; no pulse on that edge.
  - Pulse timing: first repeat pulse lands exactly REPEAT_DELAY edges after the press pulse; later pulses are spaced REPEAT_PERIOD edges apart.
  - While the other channel's level is 1: the repeat counter holds and no repeat pulses are emitted; counting resumes when the other channel is released.
- Not defined: no FSM and no repeat counters are synthesised. A hold produces exactly one pulse.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, 20 ns clock):
- Clean press: UP rises 2 ns before edge k and stays high.
  - Expect up_level=1 and up_pulse=1 after edge k+5.
  - up_pulse=0 after edge k+6.
  - down_pulse stays 0.
- Glitch rejection: DOWN high for 3 cycles, then low 1 cycle, then high for 3 cycles, then low.
  - Expect down_level and down_pulse to stay 0 throughout.
- Both buttons: UP and DOWN rise before the same edge.
  - Expect both levels=1 after edge k+5, both pulses 0 for the entire hold.
  - Release DOWN, then re-press DOWN while UP is still held: no down_pulse.
- Reset mid-count: UP rises; rst_n pulses low for 1 ns two edges later; UP stays high.
  - Expect outputs 0 immediately on rst_n low.
  - Expect up_pulse 6 edges after rst_n returns high (first sampling edge counted as 1), one cycle wide.
- AUTO_REPEAT_EN: hold UP for 40 cycles.
  - Expect up_pulse at press edge p, then p+10, p+15, p+20, ... while held.
  - No pulse on release.
- Without AUTO_REPEAT_EN: same 40-cycle hold.
  - Expect exactly one up_pulse.
